// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with registered reads, issue scoreboard and fixed-index taps; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SYSCALL_IDX = 2,
  parameter int STDOUT_IDX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              busy_1,
  output logic              busy_2,
  output logic [DATA_W-1:0] sys_call_reg,
  output logic [DATA_W-1:0] std_out_address
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SYS_A = ADDR_W'(SYSCALL_IDX);
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(STDOUT_IDX);
  logic [DATA_W-1:0] file [DEPTH];
  logic [DEPTH-1:0] pend;
  logic wr;
  logic iss;
  logic [DATA_W-1:0] rv_1, rv_2;
  assign wr = reg_write && write_reg != '0;
  assign iss = issue_en && issue_reg != '0;
`ifdef REGFILE_BYPASS_EN
  assign rv_1 = (wr && write_reg == read_reg_1) ? write_data : file[read_reg_1];
  assign rv_2 = (wr && write_reg == read_reg_2) ? write_data : file[read_reg_2];
`else
  assign rv_1 = file[read_reg_1];
  assign rv_2 = file[read_reg_2];
`endif
  assign busy_1 = pend[read_reg_1];
  assign busy_2 = pend[read_reg_2];
  assign sys_call_reg = file[SYS_A];
  assign std_out_address = file[OUT_A];
  // storage, read registers and scoreboard; register 0 and pend[0] are only ever cleared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) file[i] <= '0;
      pend <= '0;
      read_data_1 <= '0;
      read_data_2 <= '0;
    end else begin
      if (wr) file[write_reg] <= write_data;
      if (rd_en) begin
        read_data_1 <= rv_1;
        read_data_2 <= rv_2;
      end
      if (wr) pend[write_reg] <= 1'b0;
      if (iss) pend[issue_reg] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed and random checks of regfile_param against an array-based model
module tb_regfile_param;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_en = 1'b0;
  logic [4:0] read_reg_1 = '0, read_reg_2 = '0, write_reg = '0, issue_reg = '0;
  logic [31:0] read_data_1, read_data_2, write_data = '0, sys_call_reg, std_out_address;
  logic reg_write = 1'b0, issue_en = 1'b0;
  logic busy_1, busy_2;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mdl [32];
  bit [31:0] pm;
  logic [31:0] er1, er2;

  regfile_param dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .issue_en(issue_en), .issue_reg(issue_reg),
    .busy_1(busy_1), .busy_2(busy_2),
    .sys_call_reg(sys_call_reg), .std_out_address(std_out_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && reg_write && write_reg == a) return write_data;
    return mdl[a];
  endfunction

  task automatic drive(input bit rn, input bit rw, input logic [4:0] wa, input logic [31:0] wd,
                       input bit re, input logic [4:0] a1, input logic [4:0] a2,
                       input bit ie, input logic [4:0] ia);
    rst_n = rn; reg_write = rw; write_reg = wa; write_data = wd; rd_en = re;
    read_reg_1 = a1; read_reg_2 = a2; issue_en = ie; issue_reg = ia;
  endtask

  task automatic step(input string tag);
    #1;
    chk({tag, ".busy_1"}, {31'b0, busy_1}, {31'b0, read_reg_1 != 0 && pm[read_reg_1]});
    chk({tag, ".busy_2"}, {31'b0, busy_2}, {31'b0, read_reg_2 != 0 && pm[read_reg_2]});
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      pm = '0; er1 = '0; er2 = '0;
    end else begin
      if (rd_en) begin er1 = rd_val(read_reg_1); er2 = rd_val(read_reg_2); end
      if (reg_write && write_reg != 0) begin mdl[write_reg] = write_data; pm[write_reg] = 1'b0; end
      if (issue_en && issue_reg != 0) pm[issue_reg] = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ".read_data_1"}, read_data_1, er1);
    chk({tag, ".read_data_2"}, read_data_2, er2);
    chk({tag, ".sys_call_reg"}, sys_call_reg, mdl[2]);
    chk({tag, ".std_out_address"}, std_out_address, mdl[4]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    pm = '0; er1 = '0; er2 = '0;
    drive(0, 1, 5'd7, 32'h1111, 1, 5'd7, 5'd7, 1, 5'd7);
    @(posedge clk); #1;
    step("reset");
    chk("reset.sys", sys_call_reg, 32'h0);
    drive(1, 0, 0, 0, 1, 5'd5, 5'd31, 0, 0); step("r032");
    chk("r032.rd1", read_data_1, 32'h0);
    chk("r032.rd2", read_data_2, 32'h0);
    drive(1, 1, 5'd8, 32'hDEADBEEF, 0, 0, 0, 0, 0); step("r033w");
    drive(1, 0, 0, 0, 1, 5'd8, 5'd8, 0, 0); step("r033r");
    chk("r033.rd1", read_data_1, 32'hDEADBEEF);
    chk("r033.rd2", read_data_2, 32'hDEADBEEF);
    drive(1, 1, 5'd0, 32'h12345678, 0, 0, 0, 0, 0); step("r034w");
    drive(1, 0, 0, 0, 1, 5'd0, 5'd8, 1, 5'd0); step("r034r");
    chk("r034.rd1", read_data_1, 32'h0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0); step("r034busy");
    chk("r034.busy", {31'b0, busy_1}, 32'h0);
    drive(1, 1, 5'd3, 32'hA5A5A5A5, 1, 5'd3, 5'd3, 0, 0); step("r035");
    chk("r035.rd1", read_data_1, BYP ? 32'hA5A5A5A5 : 32'h0);
    drive(1, 0, 0, 0, 1, 5'd3, 5'd1, 0, 0); step("r035next");
    chk("r035next.rd1", read_data_1, 32'hA5A5A5A5);
    drive(1, 0, 0, 0, 0, 5'd9, 5'd9, 1, 5'd9); step("r036issue");
    chk("r036.busy_set", {31'b0, busy_1}, 32'h1);
    drive(1, 1, 5'd9, 32'h99, 0, 5'd9, 5'd9, 1, 5'd9); step("r036both");
    chk("r036.busy_keep", {31'b0, busy_1}, 32'h1);
    drive(1, 1, 5'd9, 32'h98, 0, 5'd9, 5'd9, 0, 0); step("r036write");
    chk("r036.busy_clr", {31'b0, busy_1}, 32'h0);
    drive(1, 1, 5'd2, 32'd10, 0, 5'd9, 5'd2, 1, 5'd2); step("r037a");
    drive(1, 1, 5'd4, 32'h1000, 0, 5'd2, 5'd9, 0, 0); step("r037b");
    chk("r037.sys", sys_call_reg, 32'd10);
    chk("r037.out", std_out_address, 32'h1000);
    chk("r037.busy", {31'b0, busy_1}, 32'h1);
    drive(0, 1, 5'd2, 32'h77, 1, 5'd2, 5'd4, 1, 5'd4); step("r037rst");
    chk("r037.sys0", sys_call_reg, 32'h0);
    chk("r037.out0", std_out_address, 32'h0);
    chk("r037.busy0", {31'b0, busy_1}, 32'h0);
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(49) != 0, $urandom_range(1), 5'($urandom), $urandom,
            $urandom_range(1), 5'($urandom_range(7)), 5'($urandom_range(7)),
            $urandom_range(2) == 0, 5'($urandom_range(7)));
      step("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL provide parameter SYSCALL_IDX, default 2, register index driven on sys_call_reg.
REQ-004 SHALL provide parameter STDOUT_IDX, default 4, register index driven on std_out_address.
REQ-005 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 rd_en  input  1  read strobe for both read ports.
REQ-008 read_reg_1, read_reg_2  input  ADDR_W  read addresses.
REQ-009 read_data_1, read_data_2  output  DATA_W  registered read data.
REQ-010 reg_write  input  1  write enable.
REQ-011 write_reg  input  ADDR_W  write address.
REQ-012 write_data  input  DATA_W  write data.
REQ-013 issue_en  input  1  mark issue_reg pending (scoreboard set).
REQ-014 issue_reg  input  ADDR_W  destination being issued.
REQ-015 busy_1, busy_2  output  1  pending status of read_reg_1 / read_reg_2, combinational.
REQ-016 sys_call_reg, std_out_address  output  DATA_W  contents of SYSCALL_IDX / STDOUT_IDX.

Function
REQ-017 Write: on rising edge with rst_n=1, reg_write=1, write_reg!=0, file[write_reg] SHALL take write_data.
REQ-018 Register 0 SHALL read as 0 always; writes and issues to address 0 SHALL be ignored.
REQ-019 Read: on rising edge with rd_en=1, read_data_1/2 SHALL load file[read_reg_1/2]; latency 1 cycle; rd_en=0 holds previous values.
REQ-020 Same-edge read and write to same nonzero address: result per REQ-030 (bypass) or old value (no bypass).
REQ-021 Scoreboard: one pending bit per register; issue_en=1 sets bit[issue_reg]; reg_write=1 clears bit[write_reg].
REQ-022 Simultaneous issue and write to same address SHALL leave pending set (issue wins).
REQ-023 busy_1/busy_2 SHALL equal pending bit of read_reg_1/read_reg_2 as of the current cycle, 0 for address 0.
REQ-024 sys_call_reg/std_out_address SHALL continuously reflect committed file contents (visible the cycle after the write edge).
REQ-025 Two ports reading the same address SHALL return identical data.

Reset
REQ-026 While rst_n=0 at a rising edge, all registers, read_data_1/2 and all pending bits SHALL become 0 in that one edge.
REQ-027 reg_write, issue_en and rd_en SHALL be ignored during reset; reset asserted mid-sequence discards the in-flight write.
REQ-028 After reset, sys_call_reg=0, std_out_address=0, busy_1=busy_2=0.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 Defined: same-edge read of write_reg (nonzero, reg_write=1) SHALL return write_data on read_data_x.
REQ-031 Undefined: such a read SHALL return the pre-write value; new value visible on next read.

Verification
REQ-032 Reset, then rd_en with read_reg_1=5, read_reg_2=31 -> read_data_1=0, read_data_2=0, busy_1=busy_2=0.
REQ-033 Write 0xDEADBEEF to reg 8, next cycle read reg 8 on both ports -> both read_data = 0xDEADBEEF one cycle later.
REQ-034 Write 0x12345678 to reg 0, read reg 0 -> read_data_1=0; issue_en to reg 0 -> busy stays 0.
REQ-035 Same edge write 0xA5A5A5A5 to reg 3 and read reg 3 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, previous value (0) without.
REQ-036 Issue reg 9 -> busy_1=1 for read_reg_1=9; same-edge issue+write reg 9 -> busy stays 1; write only -> busy 0.
REQ-037 Write 10 to reg 2 and 0x1000 to reg 4, then rst_n=0 one edge -> sys_call_reg 10 then 0, std_out_address 0x1000 then 0.
